// File: rtl/l2_line_adaptor.sv
// Adapts 256-bit L2 line requests to a 64-bit burst memory port: four beats per
// line, packing read beats into the line buffer and slicing it for writebacks.
module l2_line_adaptor #(
  parameter int S_LINE   = 256,
  parameter int S_BURST  = 64,
  parameter int BEATS    = S_LINE / S_BURST,
  parameter int S_OFFSET = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [S_LINE-1:0]  line_i,
  output logic [S_LINE-1:0]  line_o,
  output logic               resp_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  output logic [S_BURST-1:0] burst_o,
  input  logic [S_BURST-1:0] burst_i,
  input  logic               resp_i
);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  beat;
  logic [S_LINE-1:0] line_buf;
  logic [31:0]       addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (read_i) state_nxt = READ;
               else if (write_i) state_nxt = WRITE;
      READ:    if (resp_i && beat == LAST) state_nxt = DONE;
      WRITE:   if (resp_i && beat == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read wins over a simultaneous write, so the writeback line is only captured
  // when read_i is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat     <= '0;
      addr     <= '0;
      line_buf <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (read_i || write_i) begin
            addr <= {address_i[31:S_OFFSET], {S_OFFSET{1'b0}}};
            beat <= '0;
            if (!read_i) line_buf <= line_i;
          end
        end
        READ: begin
          if (resp_i) begin
            line_buf[S_BURST*beat +: S_BURST] <= burst_i;
            beat <= beat + CNT_W'(1);
          end
        end
        WRITE: begin
          if (resp_i) beat <= beat + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign read_o    = (state == READ);
  assign write_o   = (state == WRITE);
  assign resp_o    = (state == DONE);
  assign address_o = addr;
  assign line_o    = line_buf;
  assign burst_o   = line_buf[S_BURST*beat +: S_BURST];

endmodule

// File: tb/tb_l2_line_adaptor.sv
// Bench for l2_line_adaptor: directed and randomized line transfers against a
// line-level model (expected line = beats concatenated, beat k = slice k).
module tb_l2_line_adaptor;
  localparam int S_LINE  = 256;
  localparam int S_BURST = 64;
  localparam int BEATS   = S_LINE / S_BURST;

  logic               clk = 1'b0;
  logic               rst;
  logic [31:0]        address_i;
  logic               read_i, write_i;
  logic [S_LINE-1:0]  line_i;
  logic [S_LINE-1:0]  line_o;
  logic               resp_o;
  logic [31:0]        address_o;
  logic               read_o, write_o;
  logic [S_BURST-1:0] burst_o;
  logic [S_BURST-1:0] burst_i;
  logic               resp_i;

  int passed = 0;
  int total  = 0;

  l2_line_adaptor #(.S_LINE(S_LINE), .S_BURST(S_BURST), .BEATS(BEATS), .S_OFFSET(5)) dut (
    .clk(clk), .rst(rst), .address_i(address_i), .read_i(read_i), .write_i(write_i),
    .line_i(line_i), .line_o(line_o), .resp_o(resp_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .burst_o(burst_o), .burst_i(burst_i),
    .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  function automatic logic [S_LINE-1:0] rand_line();
    logic [S_LINE-1:0] r;
    for (int i = 0; i < S_LINE / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Read transfer: mode 0 = no gaps, 1 = pattern 1,0,1,0,0,1,1, 2 = random gaps.
  task automatic run_read(input logic [31:0] addr, input logic [S_LINE-1:0] line,
                          input int mode, input bit both, input string name);
    int k = 0;
    int cyc = 0;
    logic [6:0] pat = 7'b1100101;
    logic r;
    logic [31:0] exp_addr = addr & 32'hFFFF_FFE0;
    address_i = addr; read_i = 1'b1; write_i = both; line_i = rand_line(); resp_i = 1'b0;
    while (k < BEATS) begin
      @(negedge clk);
      cyc++;
      total++; if (read_o !== 1'b1) $display("FAIL %s read_o cyc%0d got %b exp 1", name, cyc, read_o); else passed++;
      total++; if (write_o !== 1'b0) $display("FAIL %s write_o cyc%0d got %b exp 0", name, cyc, write_o); else passed++;
      total++; if (resp_o !== 1'b0) $display("FAIL %s early resp_o cyc%0d got %b exp 0", name, cyc, resp_o); else passed++;
      total++; if (address_o !== exp_addr) $display("FAIL %s address_o got %h exp %h", name, address_o, exp_addr); else passed++;
      address_i = $urandom;
      line_i = rand_line();
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc <= 7) ? pat[cyc-1] : 1'b1;
        default: r = (cyc > 20) ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
      resp_i = r;
      burst_i = r ? line[S_BURST*k +: S_BURST] : {$urandom, $urandom};
      if (r) k++;
    end
    @(negedge clk);
    total++; if (resp_o !== 1'b1) $display("FAIL %s resp_o got %b exp 1", name, resp_o); else passed++;
    total++; if (read_o !== 1'b0) $display("FAIL %s read_o in done got %b exp 0", name, read_o); else passed++;
    total++; if (write_o !== 1'b0) $display("FAIL %s write_o in done got %b exp 0", name, write_o); else passed++;
    total++; if (line_o !== line) $display("FAIL %s line_o got %h exp %h", name, line_o, line); else passed++;
    total++; if (address_o !== exp_addr) $display("FAIL %s address_o done got %h exp %h", name, address_o, exp_addr); else passed++;
    read_i = 1'b0; write_i = 1'b0; resp_i = 1'b1; burst_i = {$urandom, $urandom};
    @(negedge clk);
    total++; if (resp_o !== 1'b0) $display("FAIL %s resp_o idle got %b exp 0", name, resp_o); else passed++;
    total++; if (read_o !== 1'b0) $display("FAIL %s read_o idle got %b exp 0", name, read_o); else passed++;
    total++; if (line_o !== line) $display("FAIL %s line_o after done got %h exp %h", name, line_o, line); else passed++;
    resp_i = 1'b0;
  endtask

  task automatic run_write(input logic [31:0] addr, input logic [S_LINE-1:0] line,
                           input int mode, input string name);
    int k = 0;
    int cyc = 0;
    logic r;
    logic [31:0] exp_addr = addr & 32'hFFFF_FFE0;
    address_i = addr; write_i = 1'b1; read_i = 1'b0; line_i = line; resp_i = 1'b0;
    while (k < BEATS) begin
      @(negedge clk);
      cyc++;
      total++; if (write_o !== 1'b1) $display("FAIL %s write_o cyc%0d got %b exp 1", name, cyc, write_o); else passed++;
      total++; if (read_o !== 1'b0) $display("FAIL %s read_o cyc%0d got %b exp 0", name, cyc, read_o); else passed++;
      total++; if (resp_o !== 1'b0) $display("FAIL %s early resp_o cyc%0d got %b exp 0", name, cyc, resp_o); else passed++;
      total++; if (address_o !== exp_addr) $display("FAIL %s address_o got %h exp %h", name, address_o, exp_addr); else passed++;
      total++; if (burst_o !== line[S_BURST*k +: S_BURST])
        $display("FAIL %s burst_o beat%0d got %h exp %h", name, k, burst_o, line[S_BURST*k +: S_BURST]); else passed++;
      address_i = $urandom;
      line_i = rand_line();
      r = (mode == 0 || cyc > 20) ? 1'b1 : 1'($urandom_range(0, 1));
      resp_i = r;
      burst_i = {$urandom, $urandom};
      if (r) k++;
    end
    @(negedge clk);
    total++; if (resp_o !== 1'b1) $display("FAIL %s resp_o got %b exp 1", name, resp_o); else passed++;
    total++; if (write_o !== 1'b0) $display("FAIL %s write_o in done got %b exp 0", name, write_o); else passed++;
    total++; if (line_o !== line) $display("FAIL %s line buffer got %h exp %h", name, line_o, line); else passed++;
    write_i = 1'b0; resp_i = 1'b1;
    @(negedge clk);
    total++; if (resp_o !== 1'b0) $display("FAIL %s resp_o idle got %b exp 0", name, resp_o); else passed++;
    total++; if (write_o !== 1'b0) $display("FAIL %s write_o idle got %b exp 0", name, write_o); else passed++;
    resp_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; address_i = '0; read_i = 1'b0; write_i = 1'b0; line_i = '0;
    burst_i = '0; resp_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    address_i = 32'hDEAD_BEEF; line_i = rand_line() | 256'h1; write_i = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (read_o !== 1'b0) $display("FAIL reset read_o got %b exp 0", read_o); else passed++;
    total++; if (write_o !== 1'b0) $display("FAIL reset write_o got %b exp 0", write_o); else passed++;
    total++; if (resp_o !== 1'b0) $display("FAIL reset resp_o got %b exp 0", resp_o); else passed++;
    total++; if (address_o !== 32'h0) $display("FAIL reset address_o got %h exp 0", address_o); else passed++;
    total++; if (line_o !== '0) $display("FAIL reset line_o got %h exp 0", line_o); else passed++;
    total++; if (burst_o !== '0) $display("FAIL reset burst_o got %h exp 0", burst_o); else passed++;
    write_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    resp_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      burst_i = {$urandom, $urandom};
      @(negedge clk);
      total++; if ({read_o, write_o, resp_o} !== 3'b000)
        $display("FAIL reset idle%0d req/resp got %b exp 000", i, {read_o, write_o, resp_o}); else passed++;
    end
    total++; if (line_o !== '0) $display("FAIL idle resp_i line_o got %h exp 0", line_o); else passed++;
    resp_i = 1'b0;
  endtask

  task automatic test_read_nogap();
    run_read(32'h1234_5678, {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}}, 0, 1'b0, "read_nogap");
  endtask

  task automatic test_read_gaps();
    run_read(32'h1234_5678, rand_line(), 1, 1'b0, "read_gaps");
  endtask

  task automatic test_write();
    run_write(32'h8000_001F, {{16{4'hA}}, {16{4'hB}}, {16{4'hC}}, {16{4'hD}}}, 0, "write");
  endtask

  task automatic test_back_to_back();
    run_write($urandom, rand_line(), 0, "b2b_write");
    run_read($urandom, rand_line(), 0, 1'b0, "b2b_read");
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) run_write($urandom, rand_line(), 2, "rand_write");
      else            run_read($urandom, rand_line(), 2, 1'b0, "rand_read");
    end
  endtask

  task automatic test_reset_mid_read();
    logic [S_LINE-1:0] line = rand_line();
    address_i = $urandom; read_i = 1'b1; resp_i = 1'b0;
    @(negedge clk);
    resp_i = 1'b1; burst_i = line[63:0];
    @(negedge clk);
    burst_i = line[127:64];
    @(negedge clk);
    total++; if (read_o !== 1'b1) $display("FAIL abort read_o before rst got %b exp 1", read_o); else passed++;
    resp_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++; if (read_o !== 1'b0) $display("FAIL abort read_o got %b exp 0", read_o); else passed++;
    total++; if (line_o !== '0) $display("FAIL abort line_o got %h exp 0", line_o); else passed++;
    read_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if ({resp_o, read_o} !== 2'b00)
        $display("FAIL abort no resp cyc%0d got %b exp 00", i, {resp_o, read_o}); else passed++;
    end
    run_read($urandom, rand_line(), 0, 1'b0, "read_after_abort");
  endtask

  task automatic test_read_write_both();
    run_read($urandom, rand_line(), 2, 1'b1, "read_and_write");
  endtask

  initial begin
    test_reset();
    test_read_nogap();
    test_read_gaps();
    test_write();
    test_back_to_back();
    test_reset_mid_read();
    test_read_write_both();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
